ram_bus_ctrl: RTL and testbench

Bus-side sequencer that sits directly upstream of the 16×4 RAM and is its only driver of `wen`, `addr` and `Din`. It accepts single commands over a valid/ready handshake: word read, word write, block fill and block copy. It expands each command into a cycle-by-cycle RAM access sequence and returns read data plus a completion pulse. The RAM's combinational `Qout` feeds back into `ram_q`.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_addr_gen.sv | 41 ++++
 rtl/ram_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ram_bus_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared widths, command codes and controller states for the RAM bus sequencer.
// RAM_BUS_COPY_EN adds the block-copy states.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 4;
  localparam int unsigned BUS_DATA_W = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_COPY  = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
`ifdef RAM_BUS_COPY_EN
    S_CP_RD = 3'd4,
    S_CP_WR = 3'd5,
`endif
    S_FILL  = 3'd3
  } bus_state_t;

endpackage

// File: rtl/bus_addr_gen.sv
// Word index counter for block commands: base+i address generation and last-word flag.
// RAM_BUS_COPY_EN adds the source address path.
module bus_addr_gen
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] dst_base,
`ifdef RAM_BUS_COPY_EN
  input  logic [ADDR_W-1:0] src_base,
  output logic [ADDR_W-1:0] src_addr,
`endif
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  logic [ADDR_W-1:0] idx;

  // Index restarts at 0 while the controller is idle and advances once per word.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  assign last     = (idx == len);
  assign dst_addr = dst_base + idx;
`ifdef RAM_BUS_COPY_EN
  assign src_addr = src_base + idx;
`endif

endmodule

// File: rtl/ram_bus_ctrl.sv
// Command sequencer driving the 16x4 RAM: READ, WRITE, FILL and (with RAM_BUS_COPY_EN) COPY.
// Without RAM_BUS_COPY_EN an accepted COPY is rejected with a one-cycle err pulse.
module ram_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_q
);

  bus_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] dst_addr;
  logic              last;
  logic              gen_start;
  logic              gen_step;
`ifdef RAM_BUS_COPY_EN
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] copy_buf;
`else
  logic              unused_src;
  assign unused_src = ^cmd_src;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign gen_start = (state == S_IDLE);
`ifdef RAM_BUS_COPY_EN
  assign gen_step  = (state == S_FILL) || (state == S_CP_WR);
`else
  assign gen_step  = (state == S_FILL);
`endif

  bus_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .clr      (clr),
    .start    (gen_start),
    .step     (gen_step),
    .len      (len_q),
    .dst_base (addr_q),
`ifdef RAM_BUS_COPY_EN
    .src_base (src_q),
    .src_addr (src_addr),
`endif
    .dst_addr (dst_addr),
    .last     (last)
  );

  // Command FSM: accepts in IDLE, walks the access sequence, issues the completion pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef RAM_BUS_COPY_EN
      src_q    <= '0;
      copy_buf <= '0;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            data_q <= cmd_data;
`ifdef RAM_BUS_COPY_EN
            src_q  <= cmd_src;
`endif
            case (bus_op_t'(cmd_op))
              OP_READ:  state <= S_RD;
              OP_WRITE: state <= S_WR;
              OP_FILL:  state <= S_FILL;
`ifdef RAM_BUS_COPY_EN
              OP_COPY:  state <= S_CP_RD;
`else
              OP_COPY:  err   <= 1'b1;
`endif
              default:  state <= S_IDLE;
            endcase
          end
        end
        S_RD: begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        S_WR: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_FILL: begin
          if (last) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
`ifdef RAM_BUS_COPY_EN
        S_CP_RD: begin
          copy_buf <= ram_q;
          state    <= S_CP_WR;
        end
        S_CP_WR: begin
          if (last) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_CP_RD;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the RAM bus from the current state and latched command.
  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      S_RD: begin
        ram_addr = addr_q;
      end
      S_WR: begin
        ram_wen  = 1'b1;
        ram_addr = addr_q;
        ram_din  = data_q;
      end
      S_FILL: begin
        ram_wen  = 1'b1;
        ram_addr = dst_addr;
        ram_din  = data_q;
      end
`ifdef RAM_BUS_COPY_EN
      S_CP_RD: begin
        ram_addr = src_addr;
      end
      S_CP_WR: begin
        ram_wen  = 1'b1;
        ram_addr = dst_addr;
        ram_din  = copy_buf;
      end
`endif
      default: begin
        ram_wen  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Self-checking bench for ram_bus_ctrl: a behavioural RAM, a per-cycle expected-trace model,
// directed literal checks and randomized commands with occasional resets.
module tb_ram_bus_ctrl;
  import bus_pkg::*;

  localparam int unsigned AW    = BUS_ADDR_W;
  localparam int unsigned DW    = BUS_DATA_W;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          ready;
    logic          done;
    logic          rdv;
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  exp_t          q [$];
  logic          m_ready = 1'b0;
  logic [DW-1:0] exp_rd = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int wen_cnt = 0;
  int busy_cnt = 0;

  ram_bus_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_src   (cmd_src),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  assign ram_q = ram[ram_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] dn,
                              input logic rdy, input logic dne, input logic rv, input logic er,
                              input logic [DW-1:0] rd);
    exp_t e;
    e.wen = w; e.addr = ad; e.din = dn; e.ready = rdy;
    e.done = dne; e.rdv = rv; e.err = er; e.rd = rd;
    return e;
  endfunction

  // Expected bus trace of one accepted command, one entry per cycle, ending with its completion cycle.
  task automatic expand(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] s,
                        input logic [AW-1:0] l, input logic [DW-1:0] d);
    logic [AW-1:0] pd;
    logic [AW-1:0] ps;
    logic [DW-1:0] v;
    logic [DW-1:0] scr [DEPTH];
    case (op)
      2'd0: begin
        q.push_back(mk(1'b0, a, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, ref_mem[a]));
      end
      2'd1: begin
        q.push_back(mk(1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      end
      2'd2: begin
        for (int i = 0; i <= int'(l); i++) begin
          pd = a + AW'(i);
          q.push_back(mk(1'b1, pd, d, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        end
        q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0));
      end
      default: begin
`ifdef RAM_BUS_COPY_EN
        scr = ref_mem;
        for (int i = 0; i <= int'(l); i++) begin
          ps = s + AW'(i);
          pd = a + AW'(i);
          v  = scr[ps];
          scr[pd] = v;
          q.push_back(mk(1'b0, ps, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
          q.push_back(mk(1'b1, pd, v, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        end
        q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0));
`else
        q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0));
`endif
      end
    endcase
  endtask

  // RAM model, cycle counter and command acceptance as the model sees it.
  always @(posedge clk) begin
    cyc++;
    if (ram_wen) begin
      ram[ram_addr] = ram_din;
      wen_cnt++;
    end
    if (!clr && cmd_valid && m_ready) begin
      expand(cmd_op, cmd_addr, cmd_src, cmd_len, cmd_data);
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  // Per-cycle comparison of every DUT output against the expected trace.
  always @(negedge clk) begin
    exp_t e;
    if (!cmd_ready) busy_cnt++;
    if (done) done_cnt++;
    if (clr) begin
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_wen", int'(ram_wen), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_err", int'(err), 0);
      q.delete();
      exp_rd  = '0;
      m_ready = 1'b0;
    end else begin
      if (q.size() > 0) e = q.pop_front();
      else e = mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      if (e.wen) ref_mem[e.addr] = e.din;
      if (e.rdv) exp_rd = e.rd;
      chk("ram_wen", int'(ram_wen), int'(e.wen));
      chk("ram_addr", int'(ram_addr), int'(e.addr));
      chk("ram_din", int'(ram_din), int'(e.din));
      chk("cmd_ready", int'(cmd_ready), int'(e.ready));
      chk("done", int'(done), int'(e.done));
      chk("rd_valid", int'(rd_valid), int'(e.rdv));
      chk("err", int'(err), int'(e.err));
      chk("rd_data", int'(rd_data), int'(exp_rd));
      m_ready = e.ready;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] s,
                       input logic [AW-1:0] l, input logic [DW-1:0] d);
    int start;
    start = acc_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_src = s; cmd_len = l; cmd_data = d;
    for (int k = 0; k < 64 && acc_cnt == start; k++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  // Waits for done (which=0) or err (which=1); latency counts cycles from the acceptance edge.
  task automatic wait_pulse(input int which, input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if ((which == 0 && done) || (which == 1 && err)) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [AW-1:0] s, input logic [AW-1:0] l, input logic [DW-1:0] d,
                        input int which, input int exp_lat);
    int lat;
    issue(op, a, s, l, d);
    wait_pulse(which, 60, lat);
    chk(name, lat, exp_lat);
  endtask

  initial begin
    int w0;
    int b0;
    int d0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    @(negedge clk);

    // WRITE then READ
    do_cmd("write_done_lat", 2'd1, 4'd3, 4'd0, 4'd0, 4'h9, 0, 2);
    chk("write_ram3", int'(ram[3]), 9);
    do_cmd("read_done_lat", 2'd0, 4'd3, 4'd0, 4'd0, 4'h0, 0, 2);
    chk("read_rd_valid", int'(rd_valid), 1);
    chk("read_rd_data", int'(rd_data), 9);

    // Asynchronous reset seen without a clock edge
    @(posedge clk);
    #3 clr = 1'b1;
    #1;
    chk("async_ready", int'(cmd_ready), 1);
    chk("async_wen", int'(ram_wen), 0);
    chk("async_rd_data", int'(rd_data), 0);
    chk("async_pulses", int'({done, rd_valid, err}), 0);
    @(posedge clk);
    #2 clr = 1'b0;
    @(negedge clk);

    // FILL wrapping past the top address
    w0 = wen_cnt;
    do_cmd("fill_done_lat", 2'd2, 4'd14, 4'd0, 4'd3, 4'h5, 0, 5);
    chk("fill_wen_cycles", wen_cnt - w0, 4);
    chk("fill_ram14", int'(ram[14]), 5);
    chk("fill_ram15", int'(ram[15]), 5);
    chk("fill_ram0", int'(ram[0]), 5);
    chk("fill_ram1", int'(ram[1]), 5);
    chk("fill_ram2", int'(ram[2]), 2);

`ifdef RAM_BUS_COPY_EN
    for (int i = 0; i < 4; i++) do_cmd("seed_write", 2'd1, AW'(i), 4'd0, 4'd0, DW'(i + 1), 0, 2);
    b0 = busy_cnt;
    do_cmd("copy_done_lat", 2'd3, 4'd8, 4'd0, 4'd3, 4'h0, 0, 9);
    chk("copy_busy_cycles", busy_cnt - b0, 8);
    for (int i = 0; i < 4; i++) chk("copy_dst", int'(ram[8 + i]), i + 1);
    do_cmd("overlap_done_lat", 2'd3, 4'd1, 4'd0, 4'd2, 4'h0, 0, 7);
    for (int i = 1; i < 4; i++) chk("overlap_dst", int'(ram[i]), 1);
`else
    w0 = wen_cnt;
    d0 = done_cnt;
    do_cmd("copy_err_lat", 2'd3, 4'd8, 4'd0, 4'd3, 4'h0, 1, 1);
    repeat (10) @(negedge clk);
    chk("copy_no_done", done_cnt - d0, 0);
    chk("copy_no_wen", wen_cnt - w0, 0);
    chk("copy_ram8", int'(ram[8]), 8);
`endif

    // Reset during the third cycle of a long FILL
    d0 = done_cnt;
    issue(2'd2, 4'd4, 4'd0, 4'd7, 4'hC);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_ram4", int'(ram[4]), 12);
    chk("abort_ram5", int'(ram[5]), 12);
    chk("abort_ram6", int'(ram[6]), 6);
    chk("abort_no_done", done_cnt - d0, 0);
    do_cmd("after_abort_write", 2'd1, 4'd7, 4'd0, 4'd0, 4'h3, 0, 2);
    chk("after_abort_ram7", int'(ram[7]), 3);

    // Randomized commands, idle gaps and rare resets
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      if (clr) clr = 1'b0;
      else if ($urandom_range(0, 79) == 0) clr = 1'b1;
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr  = AW'($urandom);
      cmd_src   = AW'($urandom);
      cmd_len   = AW'($urandom);
      cmd_data  = DW'($urandom);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) chk("mem_final", int'(ram[i]), int'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
